// File: rtl/mem_interface_32bit.sv
// Load/store unit: runs one MFA/MOC handshake per request, generates byte enables and
// lane-replicated store data, and returns sign/zero-extended load data.
`timescale 1ns/1ps
module mem_interface_32bit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rw,
    input  logic [1:0]  size,
    input  logic        signed_ld,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_rw,
    output logic        mem_mfa,
    input  logic        mem_moc,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAITLOW, DONE} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [1:0]      size_reg;
    logic [1:0]      addr_lo_reg;
    logic            signed_reg;

    logic            bad_access;
    logic [3:0]      be_next;
    logic [31:0]     wdata_next;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     ld_ext;

    assign bad_access = (size == 2'b11)
                      || ((size == 2'b01) && addr_in[0])
                      || ((size == 2'b10) && (addr_in[1:0] != 2'b00));

    // Per-lane byte enable and store-data replication, computed from the request inputs.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign be_next[gi] = (size == 2'b00) ? (addr_in[1:0] == 2'(gi)) :
                                 (size == 2'b01) ? (addr_in[1] == (gi >= 2)) : 1'b1;
            assign wdata_next[8*gi +: 8] = (size == 2'b00) ? wdata_in[7:0] :
                                           (size == 2'b01) ? wdata_in[8*(gi%2) +: 8] :
                                                             wdata_in[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = mem_rdata[{addr_lo_reg, 3'b000} +: 8];
    assign half_sel = addr_lo_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_ext = mem_rdata;
        case (size_reg)
            2'b00:   ld_ext = {{24{signed_reg & byte_sel[7]}}, byte_sel};
            2'b01:   ld_ext = {{16{signed_reg & half_sel[15]}}, half_sel};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            size_reg    <= 2'b00;
            addr_lo_reg <= 2'b00;
            signed_reg  <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_be      <= 4'd0;
            mem_rw      <= 1'b0;
            mem_mfa     <= 1'b0;
            rdata       <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mem_addr    <= {addr_in[31:2], 2'b00};
                        mem_wdata   <= wdata_next;
                        mem_rw      <= rw;
                        size_reg    <= size;
                        addr_lo_reg <= addr_in[1:0];
                        signed_reg  <= signed_ld;
                        cnt_reg     <= '0;
                        busy        <= 1'b1;
                        if (bad_access) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                        end else begin
                            state_reg <= REQ;
                            mem_mfa   <= 1'b1;
                            mem_be    <= be_next;
                        end
                    end
                end
                REQ: begin
                    if (mem_moc) begin
                        if (mem_rw) begin
                            rdata <= ld_ext;
                        end
                        mem_mfa   <= 1'b0;
                        mem_be    <= 4'd0;
                        state_reg <= WAITLOW;
                    end else if (cnt_reg == CNT_LAST) begin
                        mem_mfa   <= 1'b0;
                        mem_be    <= 4'd0;
                        state_reg <= DONE;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                WAITLOW: begin
                    // Wait for memory to release MOC before completing; no timeout here.
                    if (!mem_moc) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    mem_mfa   <= 1'b0;
                    mem_be    <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_interface_32bit.sv
// Scoreboard bench for mem_interface_32bit: directed vectors push expectations, a forked
// monitor checks bus cycles at MFA rise and results at each done pulse.
`timescale 1ns/1ps
module tb_mem_interface_32bit;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        signed_ld = 1'b0;
    logic [31:0] addr_in = 32'd0;
    logic [31:0] wdata_in = 32'd0;
    logic        mem_moc = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] mem_addr, mem_wdata, rdata;
    logic [3:0]  mem_be;
    logic        mem_rw, mem_mfa, busy, done, err;

    mem_interface_32bit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .size(size),
        .signed_ld(signed_ld), .addr_in(addr_in), .wdata_in(wdata_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rw(mem_rw),
        .mem_mfa(mem_mfa), .mem_moc(mem_moc), .mem_rdata(mem_rdata), .rdata(rdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rw;
        int          len;
    } bus_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          start_cyc;
        int          lat;
    } sb_t;

    // d = cycles of MFA before MOC rises (-1: never), h = cycles MOC stays high,
    // poke = pulse start while busy.
    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          d;
        int          h;
        bit          poke;
        logic        err;
        bit          bus;
        logic [3:0]  be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    bus_t        bus_q[$];
    sb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = 32'd0;
    vec_t        vecs[15];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic monitor();
        bit   mfa_prev = 1'b0;
        int   len = 0;
        int   exp_len = 0;
        bus_t b;
        sb_t  s;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mfa_prev = 1'b0;
                len = 0;
                exp_len = 0;
                continue;
            end
            if (mem_mfa && !mfa_prev) begin
                len = 0;
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    exp_len = 0;
                    $display("FAIL unexpected_mfa: got mem_mfa=1 addr=%h expected no bus cycle", mem_addr);
                end else begin
                    b = bus_q.pop_front();
                    exp_len = b.len;
                    chk("mem_addr", mem_addr, b.addr);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, b.be});
                    chk("mem_wdata", mem_wdata, b.wdata);
                    chk("mem_rw", {31'd0, mem_rw}, {31'd0, b.rw});
                end
            end
            if (mem_mfa) len++;
            if (!mem_mfa && mfa_prev && exp_len != 0) chk("mfa_cycles", len, exp_len);
            if (!mem_mfa && mem_be != 4'd0) begin
                checks++;
                errors++;
                $display("FAIL be_idle: got mem_be=%b expected 0000 outside REQ", mem_be);
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    s = sb_q.pop_front();
                    chk("err", {31'd0, err}, {31'd0, s.err});
                    chk("rdata", rdata, s.rdata);
                    chk("latency", cyc - s.start_cyc + 1, s.lat);
                    chk("busy_at_done", {31'd0, busy}, 32'd1);
                end
            end
            mfa_prev = mem_mfa;
        end
    endtask

    task automatic run(vec_t v);
        int lat;
        int len;
        bit seen = 1'b0;
        @(negedge clk);
        rw = v.rw; size = v.size; signed_ld = v.sgn;
        addr_in = v.addr; wdata_in = v.wdata; start = 1'b1;
        if (!v.bus) begin
            lat = 1; len = 0;
        end else if (v.d < 0) begin
            lat = TIMEOUT + 1; len = TIMEOUT;
        end else begin
            lat = v.d + v.h + 2; len = v.d + 1;
        end
        if (v.bus) bus_q.push_back('{addr: {v.addr[31:2], 2'b00}, be: v.be, wdata: v.exp_wdata, rw: v.rw, len: len});
        if (!v.err && v.rw) model_rdata = v.exp_rdata;
        sb_q.push_back('{err: v.err, rdata: model_rdata, start_cyc: cyc + 1, lat: lat});
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            start = (v.poke && k == 2);
            if (start) begin
                rw = 1'b0; size = 2'b10; addr_in = 32'hFFFF_FFF0; wdata_in = 32'h1111_1111;
            end
            mem_moc = (v.d >= 0 && k >= v.d + 1 && k <= v.d + v.h);
            mem_rdata = mem_moc ? v.mrdata : 32'h5A5A_5A5A;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got no done within 60 cycles expected done for addr %h", v.addr);
        end
    endtask

    initial begin
        //           rw    size   sgn   addr           wdata          mrdata        d   h  pk err   bus  be       exp_wdata      exp_rdata
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'h0,         32'hDEAD_BEEF, 2, 1, 0, 1'b0, 1, 4'b1111, 32'h0,         32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 2'b00, 1'b1, 32'h0000_2003, 32'h0,         32'h8012_3456, 0, 1, 0, 1'b0, 1, 4'b1000, 32'h0,         32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_2003, 32'h0,         32'h8012_3456, 0, 1, 0, 1'b0, 1, 4'b1000, 32'h0,         32'h0000_0080};
        vecs[3]  = '{1'b1, 2'b01, 1'b1, 32'h0000_2002, 32'h0,         32'h8001_1234, 1, 1, 0, 1'b0, 1, 4'b1100, 32'h0,         32'hFFFF_8001};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'h1234_56AB, 32'h0,         1, 2, 0, 1'b0, 1, 4'b0010, 32'hABAB_ABAB, 32'h0};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_4001, 32'h0,         32'h0,         0, 0, 0, 1'b1, 0, 4'b0000, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 2'b10, 1'b0, 32'h0000_4002, 32'h0,         32'h0,         0, 0, 0, 1'b1, 0, 4'b0000, 32'h0,         32'h0};
        vecs[7]  = '{1'b0, 2'b11, 1'b0, 32'h0000_4000, 32'h0,         32'h0,         0, 0, 0, 1'b1, 0, 4'b0000, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h0000_5000, 32'h0,         32'h0,        -1, 0, 0, 1'b1, 1, 4'b1111, 32'h0,         32'h0};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_5004, 32'h0,         32'h0BAD_F00D, 0, 1, 0, 1'b0, 1, 4'b1111, 32'h0,         32'h0BAD_F00D};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_6002, 32'h0000_CAFE, 32'h0,         0, 1, 0, 1'b0, 1, 4'b1100, 32'hCAFE_CAFE, 32'h0};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h0000_6000, 32'h0,         32'h1234_F00D, 0, 2, 0, 1'b0, 1, 4'b0011, 32'h0,         32'h0000_F00D};
        vecs[12] = '{1'b1, 2'b00, 1'b1, 32'h0000_6001, 32'h0,         32'h1234_F00D, 1, 1, 0, 1'b0, 1, 4'b0010, 32'h0,         32'hFFFF_FFF0};
        vecs[13] = '{1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'h0,         32'h55AA_55AA, 0, 3, 1, 1'b0, 1, 4'b1111, 32'h0,         32'h55AA_55AA};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h0000_9000, 32'h0,         32'h1357_9BDF, 1, 1, 0, 1'b0, 1, 4'b1111, 32'h0,         32'h1357_9BDF};

        fork
            monitor();
        join_none

        @(negedge clk);
        @(negedge clk);
        chk("reset_mfa",   {31'd0, mem_mfa}, 32'd0);
        chk("reset_busy",  {31'd0, busy},    32'd0);
        chk("reset_done",  {31'd0, done},    32'd0);
        chk("reset_rdata", rdata,            32'd0);
        chk("reset_be",    {28'd0, mem_be},  32'd0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run(vecs[i]);

        // Abort a read in REQ with an asynchronous reset.
        @(negedge clk);
        rw = 1'b1; size = 2'b10; signed_ld = 1'b0; addr_in = 32'h0000_8000; wdata_in = 32'h0; start = 1'b1;
        bus_q.push_back('{addr: 32'h0000_8000, be: 4'b1111, wdata: 32'h0, rw: 1'b1, len: 0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mfa",   {31'd0, mem_mfa}, 32'd0);
        chk("rst_mid_busy",  {31'd0, busy},    32'd0);
        chk("rst_mid_done",  {31'd0, done},    32'd0);
        chk("rst_mid_rdata", rdata,            32'd0);
        model_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        run(vecs[14]);

        repeat (5) @(negedge clk);
        chk("sb_empty",  sb_q.size(),  32'd0);
        chk("bus_empty", bus_q.size(), 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_interface_32bit.md
# mem_interface_32bit

Memory interface unit of the datapath: accepts a load/store request from the control unit, takes its address from the `mux_8x1_32bit` address-source mux, and runs one MFA/MOC handshake to external memory. It generates byte enables and lane-replicated write data. It returns sign- or zero-extended load data, which drives one input of the operand mux. The unit detects misaligned accesses, illegal size codes and memory timeouts, and flags each with `err`.

## Interface
- `TIMEOUT`, 16: maximum cycles in REQ waiting for `mem_moc` before abort (≥2).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `rw`  in  1  1 = read (load), 0 = write (store).
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `signed_ld`  in  1  1 = sign-extend byte/halfword loads.
- `addr_in`  in  32  address from address mux output.
- `wdata_in`  in  32  store data (low bits used for byte/halfword).
- `mem_addr`  out  32  latched address, low 2 bits forced to 00.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables, little-endian (bit k = byte lane k).
- `mem_rw`  out  1  latched `rw`.
- `mem_mfa`  out  1  memory function activate.
- `mem_moc`  in  1  memory operation complete.
- `mem_rdata`  in  32  memory read data, valid while `mem_moc`=1.
- `rdata`  out  32  extended load result; held between loads.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: misaligned, illegal size, or timeout.

## Operation
- Reset (async, `rst_n`=0): state IDLE. All outputs 0, including `rdata`. Timeout counter 0. A reset during any state aborts the access immediately, and `mem_mfa` drops asynchronously.
- States: IDLE, REQ, WAITLOW, DONE.
- IDLE: on `start`=1, latch `addr_in`, `wdata_in`, `rw`, `size` and `signed_ld`.
  - If `size`=11, or halfword with `addr_in[0]`=1, or word with `addr_in[1:0]`≠00: go to DONE with err=1. No bus cycle is issued and `mem_mfa` stays 0.
  - Otherwise go to REQ and clear the counter.
- REQ: `mem_mfa`=1.
  - `mem_moc`=1 sampled: on a read, capture the extended result into `rdata`; go to WAITLOW.
  - Otherwise the counter increments. When the counter equals TIMEOUT−1 and `mem_moc`=0, go to DONE with err=1, leaving `rdata` unchanged.
- WAITLOW: `mem_mfa`=0. Stay until `mem_moc`=0 is sampled, then go to DONE with err=0. This state has no timeout.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored, not queued.
- Byte enables:
  - Byte access: `mem_be` = 0001 << `addr[1:0]`.
  - Halfword access: 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
  - Word access: 1111.
  - `mem_be` is driven for reads and writes. It is 0000 outside REQ.
- Write data:
  - Byte store: {4{wdata[7:0]}}.
  - Halfword store: {2{wdata[15:0]}}.
  - Word store: wdata unchanged.
- Read extraction: select the lane given by `addr[1:0]` (byte) or `addr[1]` (halfword). Extend to 32 bits with the top bit of the selected lane when `signed_ld`=1, otherwise with zeros.
- `mem_addr`, `mem_wdata` and `mem_rw` hold their latched values from the accept edge until the next accept.

## Timing
- Example sequence, start sampled at edge 0:
  - Cycle 1: REQ, `mem_mfa`=1.
  - If `mem_moc`=1 is sampled at edge 1, then cycle 2: WAITLOW, `mem_mfa`=0.
  - If `mem_moc`=0 is sampled at edge 2, then cycle 3: DONE, `done`=1.
  - Cycle 4: IDLE, and a new `start` is accepted at edge 4.
- Minimum latency: 3 cycles from the start edge to the `done` cycle. Back-to-back throughput: one access per 4 cycles.
- `rdata` updates on the edge where MOC is sampled in REQ, i.e. two cycles before `done`.
- Error without a bus cycle: `done`=`err`=1 in cycle 1.
- Timeout: `done`=`err`=1 in cycle TIMEOUT+1, and `mem_mfa` falls at the same edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Word read at 0x0000_1000; MOC rises 2 cycles after MFA; `mem_rdata`=0xDEAD_BEEF. Required: `mem_be`=1111, `rdata`=0xDEADBEEF, `done` pulse with err=0.
- Signed byte read at 0x...03 with `mem_rdata`=0x80xx_xxxx gives `rdata`=0xFFFF_FF80. The same read with `signed_ld`=0 gives 0x0000_0080. Halfword read at 0x...02 with `mem_rdata`=0x8001_xxxx, signed, gives 0xFFFF_8001.
- Byte store of `wdata_in`=0x1234_56AB at 0x...01. Required: `mem_wdata`=0xABAB_ABAB, `mem_be`=0010, `mem_rw`=0, `rdata` unchanged.
- Halfword at 0x...01, word at 0x...02, and `size`=11. Required for each: `mem_mfa` never asserted, `done`=`err`=1 one cycle after the start edge.
- MOC held low, TIMEOUT=16. Required: `mem_mfa` high for exactly 16 cycles, then `done`=`err`=1. A following read completes normally.
- `rst_n` asserted mid-REQ. Required: `mem_mfa`, `busy` and `done` go to 0 immediately. A `start` during busy is ignored. MOC held high for 3 cycles keeps the unit in WAITLOW until MOC falls.
